mem_req_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 71 +++++++
 rtl/mem_lane.sv | 34 +++
 rtl/mem_req_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_req_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory request controller, plus the
// simulated physical memory behind pmem_read/pmem_write.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0f;
            default: m = 8'hff;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        logic [2:0] m;
        case (sz)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    bit [63:0]   pmem_mem [bit [63:0]];
    int unsigned pmem_reads;
    int unsigned pmem_writes;
    bit [63:0]   pmem_last_addr;
    bit [63:0]   pmem_last_wdata;
    bit [7:0]    pmem_last_wmask;

    function automatic logic [63:0] pmem_read(input logic [63:0] addr);
        pmem_reads++;
        if (pmem_mem.exists(addr))
            return pmem_mem[addr];
        return 64'h0;
    endfunction

    function automatic void pmem_write(
        input logic [63:0] addr,
        input logic [63:0] wdata,
        input logic [7:0]  wmask
    );
        bit [63:0] cur;
        cur = pmem_mem.exists(addr) ? pmem_mem[addr] : 64'h0;
        for (int i = 0; i < 8; i++)
            if (wmask[i])
                cur[i*8 +: 8] = wdata[i*8 +: 8];
        pmem_mem[addr]  = cur;
        pmem_writes++;
        pmem_last_addr  = addr;
        pmem_last_wdata = wdata;
        pmem_last_wmask = wmask;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: store data/mask placement and load extraction
// with sign or zero extension.
module mem_lane
    import mem_pkg::*;
(
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] wdata_sh,
    output logic [7:0]  wmask,
    output logic [63:0] load
);

    logic [5:0]  sh;
    logic [63:0] lane;

    assign sh       = {off, 3'b000};
    assign wdata_sh = wdata << sh;
    assign wmask    = size_mask(size) << off;
    assign lane     = rdata >> sh;

    always_comb begin
        load = lane;
        case (size)
            SZ_B: load = {{56{sgn & lane[7]}}, lane[7:0]};
            SZ_H: load = {{48{sgn & lane[15]}}, lane[15:0]};
            SZ_W: load = {{32{sgn & lane[31]}}, lane[31:0]};
            SZ_D: load = lane;
        endcase
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory request controller with valid/ready
// request and response channels in front of the simulated memory.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY     = 0,
    parameter int unsigned ADDR_W      = 64,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err
);

    state_t      st, st_nx;
    logic [7:0]  cnt;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  sz_q;
    logic [63:0] addr_q, wdata_q, raw_q;
    logic [63:0] rdata_hold;
    logic        err_hold;
    logic        acc, mis;
    logic [63:0] addr_ext, base;
    logic [63:0] lane_wdata, lane_load;
    logic [7:0]  lane_wmask;

    assign addr_ext = 64'(req_addr);
    assign acc      = req_valid & req_ready;
    assign mis      = |(req_addr[2:0] & align_mask(req_size));
    assign base     = {addr_q[63:3], 3'b000};

    mem_lane u_lane (
        .off      (addr_q[2:0]),
        .size     (sz_q),
        .sgn      (sgn_q),
        .wdata    (wdata_q),
        .rdata    (raw_q),
        .wdata_sh (lane_wdata),
        .wmask    (lane_wmask),
        .load     (lane_load)
    );

    always_ff @(posedge clk) begin
        if (reset)
            st <= IDLE;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE: begin
                if (acc) begin
                    if (ALIGN_CHECK && mis)
                        st_nx = RESP;
                    else if (LATENCY == 0)
                        st_nx = ACCESS;
                    else
                        st_nx = WAIT;
                end
            end
            WAIT:   if (cnt == 8'd0) st_nx = ACCESS;
            ACCESS: st_nx = RESP;
            RESP:   if (rsp_ready) st_nx = IDLE;
        endcase
    end

    // Response fields live in the hold registers once the handshake
    // completes, so they stay put while the next request is in flight.
    always_comb begin
        req_ready = (st == IDLE);
        rsp_valid = (st == RESP);
        rsp_rdata = rdata_hold;
        rsp_err   = err_hold;
        if (st == RESP) begin
            rsp_err   = err_q;
            rsp_rdata = (err_q || we_q) ? 64'h0 : lane_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 8'd0;
            rdata_hold <= 64'h0;
            err_hold   <= 1'b0;
        end else begin
            if (acc) begin
                we_q    <= req_we;
                sz_q    <= req_size;
                sgn_q   <= req_signed;
                wdata_q <= req_wdata;
                err_q   <= ALIGN_CHECK && mis;
                addr_q  <= {addr_ext[63:3],
                            addr_ext[2:0] & ~align_mask(req_size)};
            end
            if (acc && LATENCY != 0)
                cnt <= 8'(LATENCY - 1);
            else if (st == WAIT && cnt != 8'd0)
                cnt <= cnt - 8'd1;
            if (st == ACCESS) begin
                if (we_q)
                    pmem_write(base, lane_wdata, lane_wmask);
                else
                    raw_q <= pmem_read(base);
            end
            if (rsp_valid && rsp_ready) begin
                rdata_hold <= rsp_rdata;
                err_hold   <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: a LATENCY=0 and a LATENCY=3 instance
// sharing the simulated memory.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [1:0]  req_size   [2];
    logic        req_signed [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [63:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    mem_req_ctrl #(.LATENCY(0)) d0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    mem_req_ctrl #(.LATENCY(3)) d3 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        logic [7:0]  wmask;
        logic [63:0] wsh;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[17];
    int   ncmp = 0;
    int   nbad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz,
        input logic sg, input logic [63:0] addr, input logic [63:0] wd,
        input logic [63:0] rd, input logic err, input logic [7:0] wm,
        input logic [63:0] wsh);
        vec_t v;
        v.we = we; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wd;
        v.rdata = rd; v.err = err; v.wmask = wm; v.wsh = wsh;
        return v;
    endfunction

    task automatic drive(input int w, input vec_t v);
        exp_t e;
        req_we[w]     = v.we;
        req_size[w]   = v.sz;
        req_signed[w] = v.sg;
        req_addr[w]   = v.addr;
        req_wdata[w]  = v.wdata;
        req_valid[w]  = 1'b1;
        e.rdata = v.rdata;
        e.err   = v.err;
        sbq.push_back(e);
    endtask

    // Full transaction; expects the DUT idle, called #1 after an edge.
    task automatic xact(input int w, input vec_t v, input string nm);
        int          c, k;
        int unsigned rd0, wr0;
        exp_t        e;
        k   = v.err ? 0 : (w == 0 ? 1 : 4);
        rd0 = pmem_reads;
        wr0 = pmem_writes;
        chk({nm, " req_ready"}, 64'(req_ready[w]), 64'd1);
        drive(w, v);
        @(posedge clk); #1;
        req_valid[w] = 1'b0;
        c = 0;
        while (!rsp_valid[w] && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk({nm, " latency"}, 64'(c), 64'(k));
        e = sbq.pop_front();
        chk({nm, " rdata"}, rsp_rdata[w], e.rdata);
        chk({nm, " err"}, 64'(rsp_err[w]), 64'(e.err));
        rsp_ready[w] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[w] = 1'b0;
        chk({nm, " reads"}, 64'(pmem_reads - rd0),
            64'(!v.we && !v.err));
        chk({nm, " writes"}, 64'(pmem_writes - wr0),
            64'(v.we && !v.err));
        if (v.we && !v.err) begin
            chk({nm, " waddr"}, pmem_last_addr, {v.addr[63:3], 3'b000});
            chk({nm, " wmask"}, 64'(pmem_last_wmask), 64'(v.wmask));
            chk({nm, " wdata"}, pmem_last_wdata, v.wsh);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          c;
        int unsigned rd0;
        exp_t        e;
        vec_t        v;

        tbl[0]  = mk(1, SZ_D, 0, 64'h80000000, 64'hF0E1D2C3B4A59687,
                     64'h0, 0, 8'hFF, 64'hF0E1D2C3B4A59687);
        tbl[1]  = mk(0, SZ_B, 1, 64'h80000001, 0,
                     64'hFFFFFFFFFFFFFF96, 0, 0, 0);
        tbl[2]  = mk(0, SZ_B, 0, 64'h80000001, 0,
                     64'h0000000000000096, 0, 0, 0);
        tbl[3]  = mk(0, SZ_W, 1, 64'h80000004, 0,
                     64'hFFFFFFFFF0E1D2C3, 0, 0, 0);
        tbl[4]  = mk(0, SZ_H, 0, 64'h80000006, 0,
                     64'h000000000000F0E1, 0, 0, 0);
        tbl[5]  = mk(0, SZ_H, 1, 64'h80000006, 0,
                     64'hFFFFFFFFFFFFF0E1, 0, 0, 0);
        tbl[6]  = mk(1, SZ_H, 0, 64'h80000002, 64'hABCD,
                     64'h0, 0, 8'h0C, 64'h00000000ABCD0000);
        tbl[7]  = mk(0, SZ_D, 0, 64'h80000000, 0,
                     64'hF0E1D2C3ABCD9687, 0, 0, 0);
        tbl[8]  = mk(0, SZ_W, 0, 64'h80000002, 0, 64'h0, 1, 0, 0);
        tbl[9]  = mk(0, SZ_H, 1, 64'h80000003, 0, 64'h0, 1, 0, 0);
        tbl[10] = mk(1, SZ_D, 0, 64'h80000004, 64'h1234, 64'h0, 1, 0, 0);
        tbl[11] = mk(1, SZ_B, 0, 64'h80000007, 64'h55,
                     64'h0, 0, 8'h80, 64'h5500000000000000);
        tbl[12] = mk(0, SZ_B, 1, 64'h80000007, 0,
                     64'h0000000000000055, 0, 0, 0);
        tbl[13] = mk(0, SZ_W, 0, 64'h80000004, 0,
                     64'h0000000055E1D2C3, 0, 0, 0);
        tbl[14] = mk(0, SZ_B, 1, 64'h80000000, 0,
                     64'hFFFFFFFFFFFFFF87, 0, 0, 0);
        tbl[15] = mk(0, SZ_B, 1, 64'h80000008, 0, 64'h0, 0, 0, 0);
        tbl[16] = mk(0, SZ_D, 1, 64'h80000000, 0,
                     64'h55E1D2C3ABCD9687, 0, 0, 0);

        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_size[i] = 2'd0; req_signed[i] = 1'b0;
            req_addr[i] = 64'h0; req_wdata[i] = 64'h0;
            rsp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("reset req_ready", 64'(req_ready[i]), 64'd1);
            chk("reset rsp_valid", 64'(rsp_valid[i]), 64'd0);
            chk("reset rsp_rdata", rsp_rdata[i], 64'h0);
            chk("reset rsp_err", 64'(rsp_err[i]), 64'd0);
        end

        for (int i = 0; i < 17; i++)
            xact(0, tbl[i], $sformatf("vec%0d", i));

        // Latency 3 with response backpressure and a blocked request.
        v = mk(0, SZ_D, 0, 64'h80000000, 0,
               64'h55E1D2C3ABCD9687, 0, 0, 0);
        rd0 = pmem_reads;
        drive(1, v);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        c = 0;
        while (!rsp_valid[1] && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bp latency", 64'(c), 64'd4);
        e = sbq.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk("bp rsp_valid", 64'(rsp_valid[1]), 64'd1);
            chk("bp rsp_rdata", rsp_rdata[1], e.rdata);
            chk("bp rsp_err", 64'(rsp_err[1]), 64'(e.err));
            chk("bp req_ready", 64'(req_ready[1]), 64'd0);
            req_valid[1] = 1'b1;
            req_addr[1]  = 64'h80000010;
            @(posedge clk); #1;
        end
        chk("bp still valid", 64'(rsp_valid[1]), 64'd1);
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b0;
        chk("bp idle ready", 64'(req_ready[1]), 64'd1);
        chk("bp idle valid", 64'(rsp_valid[1]), 64'd0);
        chk("bp rdata held", rsp_rdata[1], e.rdata);
        repeat (3) @(posedge clk);
        #1;
        chk("bp one read", 64'(pmem_reads - rd0), 64'd1);
        chk("bp no new rsp", 64'(rsp_valid[1]), 64'd0);

        // Reset while counting down drops the request.
        v = mk(0, SZ_W, 1, 64'h80000004, 0,
               64'h0000000055E1D2C3, 0, 0, 0);
        rd0 = pmem_reads;
        drive(1, v);
        void'(sbq.pop_back());
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("rst wait ready", 64'(req_ready[1]), 64'd0);
        reset[1] = 1'b1;
        @(posedge clk); #1;
        reset[1] = 1'b0;
        chk("rst req_ready", 64'(req_ready[1]), 64'd1);
        chk("rst rsp_valid", 64'(rsp_valid[1]), 64'd0);
        chk("rst rsp_rdata", rsp_rdata[1], 64'h0);
        chk("rst rsp_err", 64'(rsp_err[1]), 64'd0);
        c = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[1]) c++;
        end
        chk("rst no rsp", 64'(c), 64'd0);
        chk("rst no read", 64'(pmem_reads - rd0), 64'd0);
        xact(1, v, "rst fresh");

        xact(1, mk(0, SZ_H, 0, 64'h80000001, 0, 64'h0, 1, 0, 0),
             "lat3 misaligned");
        xact(1, mk(0, SZ_H, 1, 64'h80000002, 0,
                   64'hFFFFFFFFFFFFABCD, 0, 0, 0), "lat3 half");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
